issue_sb_stage: RTL and testbench

- Parametrised in-order issue stage with a countdown scoreboard.
- Sits between decode and the functional units. Accepts one decoded instruction per cycle over a valid/ready handshake and checks RAW and WAW hazards against per-register countdown counters.
- Reads operands from the architectural register file combinationally.
- Registers the instruction, its operands and a one-hot unit select toward execute.
- Generalises the fixed three-unit issue logic to N units with per-unit latency, a width parameter and backpressure from execute.

---
 rtl/issue_sb_stage.sv | 183 ++++++++++++++++++
 tb/tb_issue_sb_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_sb_stage.sv
// In-order issue stage with a per-register countdown scoreboard.
// Optional writeback bypass when ISSUE_SB_BYPASS_EN is defined.
module issue_sb_stage #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int NUNIT = 3,
    parameter int CNT_W = 4,
    parameter logic [NUNIT*CNT_W-1:0] UNIT_LAT = {4'd4, 4'd2, 4'd1},
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1,
    localparam int UW = (NUNIT > 1) ? $clog2(NUNIT) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_addra,
    input  logic [AW-1:0]   in_addrb,
    input  logic            in_check_a,
    input  logic            in_check_b,
    input  logic [AW-1:0]   in_regdest,
    input  logic            in_writereg,
    input  logic [UW-1:0]   in_unit,
    input  logic [31:0]     in_ctrl,
    output logic [AW-1:0]   rf_addra,
    output logic [AW-1:0]   rf_addrb,
    input  logic [XLEN-1:0] rf_dataa,
    input  logic [XLEN-1:0] rf_datab,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NUNIT-1:0] out_unit,
    output logic [XLEN-1:0] out_rega,
    output logic [XLEN-1:0] out_regb,
    output logic [AW-1:0]   out_regdest,
    output logic            out_writereg,
    output logic [31:0]     out_ctrl,
    output logic [31:0]     stall_cnt
);

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];

    logic             out_valid_q, out_valid_d;
    logic [NUNIT-1:0] out_unit_q, out_unit_d;
    logic [XLEN-1:0]  out_rega_q, out_rega_d;
    logic [XLEN-1:0]  out_regb_q, out_regb_d;
    logic [AW-1:0]    out_regdest_q, out_regdest_d;
    logic             out_writereg_q, out_writereg_d;
    logic [31:0]      out_ctrl_q, out_ctrl_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;

    logic [CNT_W-1:0] lat;
    logic [NUNIT-1:0] unit_oh;
    logic [CNT_W-1:0] cnt_a, cnt_b, cnt_dst;
    logic             byp_a, byp_b;
    logic             haz_a, haz_b, waw;
    logic             fire;
    logic [XLEN-1:0]  opa, opb;

    assign rf_addra = in_addra;
    assign rf_addrb = in_addrb;

    // Decode target unit into latency and one-hot select; out-of-range maps to unit 0
    always_comb begin
        lat        = UNIT_LAT[CNT_W-1:0];
        unit_oh    = '0;
        unit_oh[0] = 1'b1;
        for (int i = 0; i < NUNIT; i++) begin
            if (in_unit == UW'(i)) begin
                lat        = UNIT_LAT[i*CNT_W +: CNT_W];
                unit_oh    = '0;
                unit_oh[i] = 1'b1;
            end
        end
    end

`ifdef ISSUE_SB_BYPASS_EN
    // A source finishing this cycle can take its value from writeback
    always_comb begin
        byp_a = wb_valid && (wb_addr == in_addra) && (cnt_a == CNT_W'(1));
        byp_b = wb_valid && (wb_addr == in_addrb) && (cnt_b == CNT_W'(1));
        opa   = byp_a ? wb_data : rf_dataa;
        opb   = byp_b ? wb_data : rf_datab;
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_addr, wb_data};

    // Without bypass, operands come straight from the register file
    always_comb begin
        byp_a = 1'b0;
        byp_b = 1'b0;
        opa   = rf_dataa;
        opb   = rf_datab;
    end
`endif

    // Hazard detection and handshake
    always_comb begin
        cnt_a    = cnt_q[in_addra];
        cnt_b    = cnt_q[in_addrb];
        cnt_dst  = cnt_q[in_regdest];
        haz_a    = in_check_a && (cnt_a != '0) && !byp_a;
        haz_b    = in_check_b && (cnt_b != '0) && !byp_b;
        waw      = in_writereg && (in_regdest != '0) && (cnt_dst > lat);
        in_ready = !(haz_a || haz_b || waw) && (!out_valid_q || out_ready);
        fire     = in_valid && in_ready;
    end

    // Scoreboard countdown; an issuing write reloads its destination
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : '0;
            if (r != 0 && fire && in_writereg && in_regdest == AW'(r))
                cnt_d[r] = lat;
            if (r == 0)
                cnt_d[r] = '0;
        end
    end

    // Output register next state and stall counter
    always_comb begin
        out_valid_d    = out_valid_q;
        out_unit_d     = out_unit_q;
        out_rega_d     = out_rega_q;
        out_regb_d     = out_regb_q;
        out_regdest_d  = out_regdest_q;
        out_writereg_d = out_writereg_q;
        out_ctrl_d     = out_ctrl_q;
        stall_cnt_d    = stall_cnt_q;
        if (fire) begin
            out_valid_d    = 1'b1;
            out_unit_d     = unit_oh;
            out_rega_d     = opa;
            out_regb_d     = opb;
            out_regdest_d  = in_regdest;
            out_writereg_d = in_writereg;
            out_ctrl_d     = in_ctrl;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
            out_unit_d  = '0;
        end
        if (in_valid && !in_ready && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
            out_valid_q    <= 1'b0;
            out_unit_q     <= '0;
            out_rega_q     <= '0;
            out_regb_q     <= '0;
            out_regdest_q  <= '0;
            out_writereg_q <= 1'b0;
            out_ctrl_q     <= '0;
            stall_cnt_q    <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
            out_valid_q    <= out_valid_d;
            out_unit_q     <= out_unit_d;
            out_rega_q     <= out_rega_d;
            out_regb_q     <= out_regb_d;
            out_regdest_q  <= out_regdest_d;
            out_writereg_q <= out_writereg_d;
            out_ctrl_q     <= out_ctrl_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_unit     = out_unit_q;
    assign out_rega     = out_rega_q;
    assign out_regb     = out_regb_q;
    assign out_regdest  = out_regdest_q;
    assign out_writereg = out_writereg_q;
    assign out_ctrl     = out_ctrl_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_issue_sb_stage.sv
// Directed scoreboard bench for issue_sb_stage.
// Expected outputs are queued at issue and compared when presented.
module tb_issue_sb_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  d;
        logic        w;
        logic [31:0] ctrl;
        logic [2:0]  unit;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addra, in_addrb, in_regdest;
    logic        in_check_a, in_check_b, in_writereg;
    logic [1:0]  in_unit;
    logic [31:0] in_ctrl;
    logic [4:0]  rf_addra, rf_addrb;
    logic [31:0] rf_dataa, rf_datab;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_unit;
    logic [31:0] out_rega, out_regb;
    logic [4:0]  out_regdest;
    logic        out_writereg;
    logic [31:0] out_ctrl;
    logic [31:0] stall_cnt;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t q[$];
    logic m_ov = 1'b0;
    logic [31:0] m_stall = 0;
    logic byp_a = 1'b0;

    issue_sb_stage dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addra(in_addra), .in_addrb(in_addrb),
        .in_check_a(in_check_a), .in_check_b(in_check_b),
        .in_regdest(in_regdest), .in_writereg(in_writereg),
        .in_unit(in_unit), .in_ctrl(in_ctrl),
        .rf_addra(rf_addra), .rf_addrb(rf_addrb),
        .rf_dataa(rf_dataa), .rf_datab(rf_datab),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_unit(out_unit), .out_rega(out_rega), .out_regb(out_regb),
        .out_regdest(out_regdest), .out_writereg(out_writereg),
        .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
    );

    function automatic logic [31:0] fa(input logic [4:0] x);
        return {24'hA5A500, 3'b000, x};
    endfunction
    function automatic logic [31:0] fb(input logic [4:0] x);
        return {24'h5A5A00, 3'b000, x};
    endfunction

    assign rf_dataa = fa(rf_addra);
    assign rf_datab = fb(rf_addrb);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic ca,
                         input logic [4:0] b, input logic cb,
                         input logic [4:0] d, input logic w,
                         input logic [1:0] u, input logic [31:0] c);
        in_valid = v; in_addra = a; in_check_a = ca;
        in_addrb = b; in_check_b = cb; in_regdest = d;
        in_writereg = w; in_unit = u; in_ctrl = c;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 32'd0);
    endtask

    // One cycle: check combinational/registered outputs, update model, clock
    task automatic cyc(input logic exp_rdy);
        exp_t e;
        #1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("stall_cnt", stall_cnt, m_stall);
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("rf_addra", 32'(rf_addra), 32'(in_addra));
        if (m_ov) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL queue: got empty want entry");
            end else begin
                chk("out_rega", out_rega, q[0].a);
                chk("out_regb", out_regb, q[0].b);
                chk("out_regdest", 32'(out_regdest), 32'(q[0].d));
                chk("out_writereg", 32'(out_writereg), 32'(q[0].w));
                chk("out_ctrl", out_ctrl, q[0].ctrl);
                chk("out_unit", 32'(out_unit), 32'(q[0].unit));
                if (out_ready) void'(q.pop_front());
            end
        end else begin
            chk("out_unit_idle", 32'(out_unit), 32'd0);
        end
        if (in_valid && exp_rdy) begin
            e.a    = byp_a ? wb_data : fa(in_addra);
            e.b    = fb(in_addrb);
            e.d    = in_regdest;
            e.w    = in_writereg;
            e.ctrl = in_ctrl;
            e.unit = (in_unit < 2'd3) ? (3'b001 << in_unit) : 3'b001;
            q.push_back(e);
        end
        if (in_valid && !exp_rdy) m_stall = m_stall + 1;
        if (in_valid && exp_rdy) m_ov = 1'b1;
        else if (out_ready) m_ov = 1'b0;
        @(posedge clock);
        #2;
    endtask

    initial begin
        idle();
        out_ready = 1'b1;
        wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_unit", 32'(out_unit), 32'd0);
        chk("rst_stall", stall_cnt, 32'd0);
        chk("rst_rega", out_rega, 32'd0);
        chk("rst_ctrl", out_ctrl, 32'd0);
        #9 reset = 1'b1;
        @(posedge clock);
        #2;

        // r3 <- unit0 (lat 1); probe cnt[3]=1 then 0
        drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 2'd0, 32'h11);
        cyc(1);
        drive(0, 5'd3, 1, 5'd0, 0, 5'd0, 0, 2'd0, 32'h0);
        cyc(0);
        cyc(1);

        // RAW: r5 <- unit2 (lat 4), one idle, consumer stalls 3 cycles
        drive(1, 5'd1, 0, 5'd2, 0, 5'd5, 1, 2'd2, 32'h22);
        cyc(1);
        idle();
        cyc(1);
        drive(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 2'd1, 32'h33);
        cyc(0); cyc(0); cyc(0);
        cyc(1);
        chk("stall_after_raw", stall_cnt, 32'd3);
        idle();
        cyc(1);

        // WAW: r7 on unit2 then r7 on unit0 waits until cnt[7]<=1
        drive(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 2'd2, 32'h44);
        cyc(1);
        drive(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 2'd0, 32'h55);
        cyc(0); cyc(0); cyc(0);
        cyc(1);
        idle();
        cyc(1);

        // Backpressure: hold, then drain and issue on the same edge
        drive(1, 5'd1, 1, 5'd0, 0, 5'd8, 1, 2'd1, 32'h66);
        cyc(1);
        out_ready = 1'b0;
        drive(1, 5'd2, 1, 5'd4, 1, 5'd9, 1, 2'd0, 32'h77);
        cyc(0); cyc(0);
        out_ready = 1'b1;
        cyc(1);
        idle();
        cyc(1);

        // r0 as source and destination never stalls
        drive(1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 2'd2, 32'h88);
        cyc(1);
        drive(1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 2'd2, 32'h99);
        cyc(1);
        idle();
        cyc(1);

        // Out-of-range unit maps to unit 0 (lat 1)
        drive(1, 5'd3, 0, 5'd3, 0, 5'd10, 1, 2'd3, 32'hAA);
        cyc(1);
        drive(0, 5'd10, 1, 5'd0, 0, 5'd0, 0, 2'd0, 32'h0);
        cyc(0);
        cyc(1);

        // B-side RAW on unit1 (lat 2)
        drive(1, 5'd0, 0, 5'd0, 0, 5'd11, 1, 2'd1, 32'hBB);
        cyc(1);
        drive(0, 5'd0, 0, 5'd11, 1, 5'd0, 0, 2'd0, 32'h0);
        cyc(0); cyc(0);
        cyc(1);

        // Writeback bypass at cnt==1
        drive(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 2'd2, 32'hCC);
        cyc(1);
        idle();
        cyc(1); cyc(1); cyc(1);
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
        drive(1, 5'd5, 1, 5'd1, 0, 5'd13, 1, 2'd0, 32'hDD);
`ifdef ISSUE_SB_BYPASS_EN
        byp_a = 1'b1;
        cyc(1);
        byp_a = 1'b0;
`else
        cyc(0);
        cyc(1);
`endif
        wb_valid = 1'b0; wb_data = 32'd0;
        idle();
        cyc(1);

        // Asynchronous reset in the middle of a stall
        drive(1, 5'd0, 0, 5'd0, 0, 5'd12, 1, 2'd2, 32'hEE);
        cyc(1);
        drive(1, 5'd12, 1, 5'd0, 0, 5'd14, 0, 2'd0, 32'hFF);
        cyc(0);
        reset = 1'b0;
        #1;
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_stall", stall_cnt, 32'd0);
        chk("mrst_rega", out_rega, 32'd0);
        chk("mrst_regdest", 32'(out_regdest), 32'd0);
        chk("mrst_unit", 32'(out_unit), 32'd0);
        idle();
        reset = 1'b1;
        q.delete();
        m_ov = 1'b0;
        m_stall = 0;
        @(posedge clock);
        #2;
        drive(1, 5'd12, 1, 5'd0, 0, 5'd14, 1, 2'd1, 32'h123);
        cyc(1);
        idle();
        cyc(1);
        cyc(1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
